// File: rtl/seg_approx_adder_ecu_pkg.sv
// Shared constants, FSM state type and width helper for the segmented approximate adder.
package approx_adder_pkg;
  localparam int SEG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction
endpackage

// File: rtl/seg_approx_adder_ecu_carry_generator.sv
// 4-bit carry generator: carry-out of one segment assuming a carry-in of zero.
module carry_generator
  import approx_adder_pkg::*;
(
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  output logic             o_cout
);
  logic [SEG_W-1:0] w_g;
  logic [SEG_W-1:0] w_p;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    o_cout = 1'b0;
    for (int i = 0; i < SEG_W; i++) o_cout = w_g[i] | (w_p[i] & o_cout);
  end
endmodule

// File: rtl/seg_approx_adder_ecu.sv
// Segmented approximate adder: speculative per-segment carries give a fast sum,
// an optional FIX walk repairs mis-speculated carries one segment per cycle.
module seg_approx_adder_ecu
  import approx_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           fix_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               sum,
  output logic                           cout,
  output logic                           err_flag,
  output logic [clog2(WIDTH/SEG_W)-1:0]  fix_cnt,
  output state_t                         dbg_state
);
  localparam int NSEG = WIDTH / SEG_W;
  localparam int CW   = clog2(NSEG);
  localparam logic [CW-1:0] LAST_IDX = CW'(NSEG - 1);

  // Handshake: operands transfer on a rising edge with in_valid & in_ready;
  // the result transfers on a rising edge with out_valid & out_ready, and all
  // result outputs hold bit-stable from out_valid rising until that edge.

  logic [NSEG-1:0]  w_spec;
  logic [NSEG-1:0]  w_pall;
  logic [WIDTH-1:0] w_approx_sum;
  logic             w_approx_cout;
  logic [WIDTH:0]   w_exact;
  logic             w_err;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [NSEG-1:0]  r_spec;
  logic [NSEG-1:0]  r_pall;
  logic             r_cout;
  logic             r_err;
  logic [CW-1:0]    r_fix_cnt;
  logic [CW-1:0]    r_idx;
  logic             r_carry;

  logic [SEG_W-1:0] w_a_seg;
  logic [SEG_W-1:0] w_b_seg;
  logic [SEG_W:0]   w_seg_fix;
  logic [NSEG:0]    w_spec_ext;
  logic [CW:0]      w_idx_nxt;
  logic             w_tc_nxt;
  logic             w_last;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    assign w_pall[k] = &(a[k*SEG_W +: SEG_W] ^ b[k*SEG_W +: SEG_W]);
    if (k == 0) begin : g_first
      assign w_spec[k] = 1'b0;
    end else begin : g_cg
      carry_generator u_cg (
        .i_a    (a[(k-1)*SEG_W +: SEG_W]),
        .i_b    (b[(k-1)*SEG_W +: SEG_W]),
        .o_cout (w_spec[k])
      );
    end
    if (k == NSEG - 1) begin : g_top
      assign {w_approx_cout, w_approx_sum[k*SEG_W +: SEG_W]} =
        {1'b0, a[k*SEG_W +: SEG_W]} + {1'b0, b[k*SEG_W +: SEG_W]} + {{SEG_W{1'b0}}, w_spec[k]};
    end else begin : g_mid
      assign w_approx_sum[k*SEG_W +: SEG_W] =
        a[k*SEG_W +: SEG_W] + b[k*SEG_W +: SEG_W] + {{(SEG_W-1){1'b0}}, w_spec[k]};
    end
  end

  assign w_exact = {1'b0, a} + {1'b0, b};
  assign w_err   = ({w_approx_cout, w_approx_sum} != w_exact);

  // r_carry holds the true carry into segment r_idx while in FIX.
  assign w_a_seg    = r_a[r_idx*SEG_W +: SEG_W];
  assign w_b_seg    = r_b[r_idx*SEG_W +: SEG_W];
  assign w_seg_fix  = {1'b0, w_a_seg} + {1'b0, w_b_seg} + {{SEG_W{1'b0}}, r_carry};
  assign w_spec_ext = {1'b0, r_spec};
  assign w_idx_nxt  = {1'b0, r_idx} + (CW+1)'(1);
  assign w_tc_nxt   = w_spec_ext[w_idx_nxt] | (r_pall[r_idx] & r_carry);
  assign w_last     = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = fix_en ? FIX : DONE;
      FIX:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_spec    <= '0;
      r_pall    <= '0;
      r_cout    <= 1'b0;
      r_err     <= 1'b0;
      r_fix_cnt <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= a;
            r_b       <= b;
            r_sum     <= w_approx_sum;
            r_cout    <= w_approx_cout;
            r_spec    <= w_spec;
            r_pall    <= w_pall;
            r_err     <= w_err;
            r_fix_cnt <= '0;
            r_idx     <= CW'(1);
            r_carry   <= w_spec[1];
          end
        end
        FIX: begin
          if (r_carry != r_spec[r_idx]) begin
            r_sum[r_idx*SEG_W +: SEG_W] <= w_seg_fix[SEG_W-1:0];
            r_fix_cnt                   <= r_fix_cnt + CW'(1);
          end
          if (w_last) begin
            r_cout <= w_seg_fix[SEG_W];
          end else begin
            r_idx   <= r_idx + CW'(1);
            r_carry <= w_tc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err_flag  = r_err;
  assign fix_cnt   = r_fix_cnt;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_seg_approx_adder_ecu.sv
// Directed and randomized checks for seg_approx_adder_ecu at WIDTH=16.
module tb_seg_approx_adder_ecu;
  import approx_adder_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] vs;
    logic         vc;
    logic         ve;
    logic [1:0]   vf;
    logic [3:0]   vlat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         fix_en = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         err_flag;
  logic [1:0]   fix_cnt;
  state_t       dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  seg_approx_adder_ecu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .fix_en    (fix_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err_flag  (err_flag),
    .fix_cnt   (fix_cnt),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Reference models derived from the arithmetic definition.
  function automatic logic [W:0] model_approx(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    logic [4:0] s;
    logic       spec;
    r = '0;
    spec = 1'b0;
    for (int k = 0; k < W/4; k++) begin
      s = {1'b0, x[k*4 +: 4]} + {1'b0, y[k*4 +: 4]} + {4'b0, spec};
      r[k*4 +: 4] = s[3:0];
      if (k == W/4 - 1) r[W] = s[4];
      s = {1'b0, x[k*4 +: 4]} + {1'b0, y[k*4 +: 4]};
      spec = s[4];
    end
    return r;
  endfunction

  function automatic int model_fixes(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    int unsigned xs, ys, tcar, sp, seg;
    n = 0;
    for (int k = 1; k < W/4; k++) begin
      xs   = 32'(x) & ((32'd1 << (4*k)) - 1);
      ys   = 32'(y) & ((32'd1 << (4*k)) - 1);
      tcar = ((xs + ys) >> (4*k)) & 1;
      seg  = ((32'(x) >> (4*(k-1))) & 15) + ((32'(y) >> (4*(k-1))) & 15);
      sp   = (seg >> 4) & 1;
      if (tcar != sp) n++;
    end
    return n;
  endfunction

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tf, output int lat);
    @(negedge clk);
    a = ta; b = tb; fix_en = tf; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, cout, err_flag, fix_cnt, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b cout=%b err=%b fix=%0d sum=%h, want rdy=1 vld=0 cout=0 err=0 fix=0 sum=0000",
               in_ready, out_valid, cout, err_flag, fix_cnt, sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== IDLE || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_idle: got state=%0d rdy=%b, want state=0 rdy=1", dbg_state, in_ready);
    end
  endtask

  task automatic run_table(input vec_t v, input logic tf, input string name);
    int lat;
    send(v.va, v.vb, tf, lat);
    checks++;
    if (lat !== int'(v.vlat)) begin
      failures++;
      $display("FAIL %s_latency a=%h b=%h: got %0d want %0d", name, v.va, v.vb, lat, v.vlat);
    end
    checks++;
    if (sum !== v.vs) begin
      failures++;
      $display("FAIL %s_sum a=%h b=%h: got %h want %h", name, v.va, v.vb, sum, v.vs);
    end
    checks++;
    if (cout !== v.vc) begin
      failures++;
      $display("FAIL %s_cout a=%h b=%h: got %b want %b", name, v.va, v.vb, cout, v.vc);
    end
    checks++;
    if (err_flag !== v.ve) begin
      failures++;
      $display("FAIL %s_err a=%h b=%h: got %b want %b", name, v.va, v.vb, err_flag, v.ve);
    end
    checks++;
    if (fix_cnt !== v.vf) begin
      failures++;
      $display("FAIL %s_fix_cnt a=%h b=%h: got %0d want %0d", name, v.va, v.vb, fix_cnt, v.vf);
    end
    release_out();
  endtask

  task automatic test_approx();
    vec_t tbl [5];
    tbl = '{
      '{16'h000F, 16'h0001, 16'h0010, 1'b0, 1'b0, 2'd0, 4'd1},
      '{16'h00FF, 16'h0001, 16'h0000, 1'b0, 1'b1, 2'd0, 4'd1},
      '{16'hFFFF, 16'h0001, 16'hFF00, 1'b0, 1'b1, 2'd0, 4'd1},
      '{16'h8888, 16'h8888, 16'h1110, 1'b1, 1'b0, 2'd0, 4'd1},
      '{16'h0FFF, 16'h0001, 16'h0F00, 1'b0, 1'b1, 2'd0, 4'd1}
    };
    foreach (tbl[i]) run_table(tbl[i], 1'b0, "approx");
  endtask

  task automatic test_exact();
    vec_t tbl [5];
    tbl = '{
      '{16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b1, 2'd1, 4'd4},
      '{16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 2'd2, 4'd4},
      '{16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b1, 2'd2, 4'd4},
      '{16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 2'd0, 4'd4},
      '{16'h8888, 16'h8888, 16'h1110, 1'b1, 1'b0, 2'd0, 4'd4}
    };
    foreach (tbl[i]) run_table(tbl[i], 1'b1, "exact");
  endtask

  task automatic test_backpressure();
    int lat;
    send(16'h00FF, 16'h0001, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, cout, err_flag, fix_cnt, sum} !== {1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0100}) begin
        failures++;
        $display("FAIL backpressure_hold cycle=%0d: got vld=%b rdy=%b cout=%b err=%b fix=%0d sum=%h, want vld=1 rdy=0 cout=0 err=1 fix=1 sum=0100",
                 i, out_valid, in_ready, cout, err_flag, fix_cnt, sum);
      end
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_fix();
    vec_t v;
    @(negedge clk);
    a = 16'h0FFF; b = 16'h0001; fix_en = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (dbg_state !== FIX || sum !== 16'h0F00) begin
      failures++;
      $display("FAIL mid_fix_pre_reset: got state=%0d sum=%h, want state=1 sum=0F00", dbg_state, sum);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, cout, err_flag, fix_cnt, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000}) begin
      failures++;
      $display("FAIL mid_fix_async_reset: got rdy=%b vld=%b cout=%b err=%b fix=%0d sum=%h, want rdy=1 vld=0 cout=0 err=0 fix=0 sum=0000",
               in_ready, out_valid, cout, err_flag, fix_cnt, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = '{16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b1, 2'd2, 4'd4};
    run_table(v, 1'b1, "after_reset");
  endtask

  task automatic back_to_back_mode(input logic tf, input logic [W-1:0] a0, input int want_acc);
    int acc;
    logic [W-1:0] e;
    acc = 0;
    @(negedge clk);
    a = a0; b = 16'h0456; fix_en = tf; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX;
        checks++;
        if (sum !== e) begin
          failures++;
          $display("FAIL back_to_back_sum mode=%b: got %h want %h", tf, sum, e);
        end
      end
      if (in_valid && in_ready) begin
        acc++;
        exp_q.push_back(a + b);
        @(negedge clk);
        a = a + 16'h0101;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) begin
      if (out_valid) void'(exp_q.pop_front());
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (acc !== want_acc) begin
      failures++;
      $display("FAIL back_to_back_throughput mode=%b: got %0d accepts want %0d", tf, acc, want_acc);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL back_to_back_drain mode=%b: got %0d pending want 0", tf, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    back_to_back_mode(1'b0, 16'h0123, 5);
    back_to_back_mode(1'b1, 16'h0FFF, 2);
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] ta, tb;
    logic         tf;
    logic [W:0]   ex, ap;
    logic         e_err;
    for (int i = 0; i < 400; i++) begin
      ta = W'($urandom_range(0, 65535));
      tb = W'($urandom_range(0, 65535));
      tf = i[0];
      ex = {1'b0, ta} + {1'b0, tb};
      ap = model_approx(ta, tb);
      e_err = (ap != ex);
      send(ta, tb, tf, lat);
      checks++;
      if (tf && ({cout, sum} !== ex || fix_cnt !== 2'(model_fixes(ta, tb)) || lat !== 4)) begin
        failures++;
        $display("FAIL random_exact a=%h b=%h: got cout=%b sum=%h fix=%0d lat=%0d want cout=%b sum=%h fix=%0d lat=4",
                 ta, tb, cout, sum, fix_cnt, lat, ex[W], ex[W-1:0], model_fixes(ta, tb));
      end else if (!tf && ({cout, sum} !== ap || fix_cnt !== 2'd0 || lat !== 1)) begin
        failures++;
        $display("FAIL random_approx a=%h b=%h: got cout=%b sum=%h fix=%0d lat=%0d want cout=%b sum=%h fix=0 lat=1",
                 ta, tb, cout, sum, fix_cnt, lat, ap[W], ap[W-1:0]);
      end
      checks++;
      if (err_flag !== e_err) begin
        failures++;
        $display("FAIL random_err a=%h b=%h mode=%b: got %b want %b", ta, tb, tf, err_flag, e_err);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_approx();
    test_exact();
    test_backpressure();
    test_reset_mid_fix();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
